// File: rtl/gate_stim_checker.sv
// gate_stim_checker
// Drives a 2-input gate under test through the Gray-order sweep 00,10,11,01.
// Each vector is held for SETTLE_CYCLES clocks of settling and then one CHECK clock.
// In the CHECK clock the gate output is compared with TRUTH_TABLE[{A,B}].
// Mismatches are counted, saturating at all-ones, and a pass/done verdict is held until the next start.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a run; only honoured in IDLE or DONE
//   gate_a    out  drives input A of the gate under test
//   gate_b    out  drives input B of the gate under test
//   gate_o    in   output of the gate under test
//   busy      out  high while sweeping (SETTLE and CHECK)
//   done      out  high from the end of a run until the next accepted start
//   pass      out  valid with done; 1 when no mismatch was seen
//   mismatch  out  one-cycle pulse the cycle after a failing CHECK
//   err_cnt   out  mismatches in this run, saturating
//   vec_idx   out  index of the vector currently driven (0..3)
module gate_stim_checker #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0111,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [1:0]       vec_idx_q, vec_idx_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             bad_c;

    // Comparison of the sampled gate output against the truth table
    assign bad_c = (gate_o != TRUTH_TABLE[{gate_a_q, gate_b_q}]);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        vec_idx_d    = vec_idx_q;
        done_d       = done_q;
        pass_d       = pass_q;
        mismatch_d   = 1'b0;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    vec_idx_d    = 2'd0;
                    settle_cnt_d = '0;
                    pass_cnt_d   = '0;
                    err_cnt_d    = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + SC_W'(1);
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad_c) begin
                    mismatch_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                if ((vec_idx_q == 2'd3) && (pass_cnt_q == PASS_LAST)) begin
                    state_d   = ST_DONE;
                    vec_idx_d = 2'd0;
                    done_d    = 1'b1;
                    // Verdict includes the result of this final check
                    pass_d    = (err_cnt_d == '0);
                end else begin
                    vec_idx_d    = vec_idx_q + 2'd1;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                    if (vec_idx_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        // Gray map: 0->00, 1->10, 2->11, 3->01 ({A,B})
        gate_a_d = vec_idx_d[1] ^ vec_idx_d[0];
        gate_b_d = vec_idx_d[1];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            pass_cnt_q   <= '0;
            vec_idx_q    <= 2'd0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            vec_idx_q    <= vec_idx_d;
            gate_a_q     <= gate_a_d;
            gate_b_q     <= gate_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            mismatch_q   <= mismatch_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
    assign vec_idx  = vec_idx_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Testbench for gate_stim_checker: scoreboard queues are filled when a run is started,
// and monitor processes pop and compare whenever the design presents a vector, a mismatch pulse or a verdict.
module tb_gate_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       start2;
    int         model_sel;
    int         model_sel2;

    logic       gate_a, gate_b, gate_o, busy, done, pass, mismatch;
    logic [7:0] err_cnt;
    logic [1:0] vec_idx;
    logic       gate_a2, gate_b2, gate_o2, busy2, done2, pass2, mismatch2;
    logic [1:0] err_cnt2;
    logic [1:0] vec_idx2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int start_cyc2 = 0;

    typedef struct {
        bit p;
        int err;
        int lat;
    } done_exp_t;

    int        vec_q[$];
    int        mis_q[$];
    int        mis2_q[$];
    done_exp_t done_q[$];
    done_exp_t done2_q[$];

    // Gate models: 0 = NAND, 1 = tied high, other = AND
    function automatic logic gate_model(input int sel, input logic a, input logic b);
        case (sel)
            0:       return ~(a & b);
            1:       return 1'b1;
            default: return a & b;
        endcase
    endfunction

    assign gate_o  = gate_model(model_sel, gate_a, gate_b);
    assign gate_o2 = gate_model(model_sel2, gate_a2, gate_b2);

    gate_stim_checker u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_o   (gate_o),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .mismatch (mismatch),
        .err_cnt  (err_cnt),
        .vec_idx  (vec_idx)
    );

    gate_stim_checker #(
        .TRUTH_TABLE   (4'b0111),
        .SETTLE_CYCLES (2),
        .PASSES        (2),
        .CNT_W         (2)
    ) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .gate_a   (gate_a2),
        .gate_b   (gate_b2),
        .gate_o   (gate_o2),
        .busy     (busy2),
        .done     (done2),
        .pass     (pass2),
        .mismatch (mismatch2),
        .err_cnt  (err_cnt2),
        .vec_idx  (vec_idx2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the default instance
    int        e1;
    done_exp_t d1;
    logic      prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (vec_q.size() == 0) chk("vec_unexpected", 1, 0);
                else begin
                    e1 = vec_q.pop_front();
                    chk("vector", int'({vec_idx, gate_a, gate_b}), e1);
                end
            end
            if (mismatch) begin
                if (mis_q.size() == 0) chk("mismatch_unexpected", 1, 0);
                else chk("mismatch_err_cnt", int'(err_cnt), mis_q.pop_front());
            end
            if (done && !prev_done) begin
                chk("vec_left", vec_q.size(), 0);
                chk("mismatch_left", mis_q.size(), 0);
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d1 = done_q.pop_front();
                    chk("pass", int'(pass), int'(d1.p));
                    chk("err_cnt", int'(err_cnt), d1.err);
                    chk("done_latency", cyc - start_cyc, d1.lat);
                end
            end
        end
        prev_done = done;
    end

    // Monitor for the CNT_W=2, PASSES=2 instance
    done_exp_t d2;
    logic      prev_done2 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mismatch2) begin
                if (mis2_q.size() == 0) chk("mismatch2_unexpected", 1, 0);
                else chk("mismatch2_err_cnt", int'(err_cnt2), mis2_q.pop_front());
            end
            if (done2 && !prev_done2) begin
                chk("mismatch2_left", mis2_q.size(), 0);
                if (done2_q.size() == 0) chk("done2_unexpected", 1, 0);
                else begin
                    d2 = done2_q.pop_front();
                    chk("pass2", int'(pass2), int'(d2.p));
                    chk("err_cnt2", int'(err_cnt2), d2.err);
                    chk("done2_latency", cyc - start_cyc2, d2.lat);
                end
            end
        end
        prev_done2 = done2;
    end

    // Issue a start pulse and push the expected responses for that run
    task automatic start_run(input int inst, input int model, input int n_mis,
                             input int exp_err, input bit exp_pass, input int lat);
        done_exp_t d;
        logic [1:0] ix;
        d.p   = exp_pass;
        d.err = exp_err;
        d.lat = lat;
        @(negedge clk);
        if (inst == 1) begin
            model_sel = model;
            for (int i = 0; i < 4; i++) begin
                ix = 2'(i);
                for (int s = 0; s < 3; s++) vec_q.push_back(int'({ix, ix[1] ^ ix[0], ix[1]}));
            end
            for (int i = 1; i <= n_mis; i++) mis_q.push_back((i > 255) ? 255 : i);
            done_q.push_back(d);
            start_cyc = cyc + 1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            model_sel2 = model;
            for (int i = 1; i <= n_mis; i++) mis2_q.push_back((i > 3) ? 3 : i);
            done2_q.push_back(d);
            start_cyc2 = cyc + 1;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
        end
    endtask

    task automatic wait_done(input int inst, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((inst == 1) ? done : done2) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        start2     = 1'b0;
        model_sel  = 0;
        model_sel2 = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({gate_a, gate_b, busy, done, pass, mismatch, err_cnt, vec_idx}), 0);
        chk("reset_outputs2", int'({gate_a2, gate_b2, busy2, done2, pass2, mismatch2, err_cnt2, vec_idx2}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1 ideal NAND
        start_run(1, 0, 0, 0, 1'b1, 12);
        wait_done(1, 40);

        // T2 output tied high: only the 11 vector fails
        start_run(1, 1, 1, 1, 1'b0, 12);
        wait_done(1, 40);

        // T3 AND model: every vector fails
        start_run(1, 2, 4, 4, 1'b0, 12);
        wait_done(1, 40);

        // T4 start pulsed mid-run is ignored, then restart from DONE
        start_run(1, 0, 0, 0, 1'b1, 12);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 40);
        start_run(1, 1, 1, 1, 1'b0, 12);
        chk("restart_clears", int'({done, pass, err_cnt}), 0);
        wait_done(1, 40);

        // T5 asynchronous reset during vector 2 settle
        start_run(1, 2, 4, 4, 1'b0, 12);
        for (int i = 0; i < 20; i++) begin
            if (vec_idx == 2'd2) break;
            @(negedge clk);
        end
        chk("pre_reset_vec_idx", int'(vec_idx), 2);
        chk("pre_reset_err_cnt", int'(err_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({gate_a, gate_b, busy, done, pass, mismatch, err_cnt, vec_idx}), 0);
        vec_q.delete();
        mis_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", int'({busy, done, err_cnt}), 0);
        start_run(1, 0, 0, 0, 1'b1, 12);
        wait_done(1, 40);

        // T6 two passes, 2-bit saturating counter, AND model
        start_run(2, 2, 8, 3, 1'b0, 24);
        wait_done(2, 60);

        repeat (2) @(negedge clk);
        chk("final_queues_empty", vec_q.size() + mis_q.size() + mis2_q.size()
                                  + done_q.size() + done2_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
